// File: rtl/crc_frame_transmitter.sv
// Serial frame transmitter: preamble, header, payload and CRC-8, MSB-first on one wire.
// Every output is registered; the line idles high and a one-bit gap follows each frame.
module crc_frame_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [1:0]  SRC_ID       = 2'd0,
  parameter logic [7:0]  PREAMBLE     = 8'h7E
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_start,
  input  logic [127:0] tx_data,
  input  logic [3:0]   tx_len,
  input  logic [1:0]   tx_dest_id,
  output logic         tx_serial,
  output logic         tx_busy,
  output logic         tx_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_PAY  = 3'd3,
    S_CRC  = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  // One bit of the x^8+x^2+x+1 CRC, non-reflected.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    crc8_step = {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]     byte_cnt_q, byte_cnt_d;
  logic [127:0]   data_q, data_d;
  logic [3:0]     len_q, len_d;
  logic [1:0]     dest_q, dest_d;
  logic [7:0]     crc_q, crc_d;
  logic           serial_q, serial_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           start_s;
  logic           adv_s;
  logic           bit_end_s;
  logic           bit_s;
  logic [7:0]     hdr_s;

  // Next-state, counters, CRC and the next value of the serial line.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    len_d      = len_q;
    dest_d     = dest_q;
    done_d     = 1'b0;
    start_s    = 1'b0;
    adv_s      = 1'b0;
    bit_s      = 1'b1;
    hdr_s      = {dest_q, SRC_ID, len_q};
    bit_end_s  = (clk_cnt_q == CLK_LAST);

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          start_s    = 1'b1;
          adv_s      = 1'b1;
          state_d    = S_PRE;
          data_d     = tx_data;
          len_d      = tx_len;
          dest_d     = tx_dest_id;
          clk_cnt_d  = CW'(0);
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE, S_HDR, S_PAY, S_CRC: begin
        if (bit_end_s) begin
          clk_cnt_d = CW'(0);
          adv_s     = 1'b1;
          if (state_q == S_PAY) begin
            data_d = {data_q[126:0], 1'b0};
          end else begin
            data_d = data_q;
          end
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            case (state_q)
              S_PRE: state_d = S_HDR;
              S_HDR: begin
                byte_cnt_d = 4'd0;
                if (len_q == 4'd0) begin
                  state_d = S_CRC;
                end else begin
                  state_d = S_PAY;
                end
              end
              // Compare against len-1 so a 15-byte payload never needs count 15.
              S_PAY: begin
                if (byte_cnt_q == (len_q - 4'd1)) begin
                  state_d = S_CRC;
                end else begin
                  byte_cnt_d = byte_cnt_q + 4'd1;
                end
              end
              S_CRC:   state_d = S_GAP;
              default: state_d = S_IDLE;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (bit_end_s) begin
          state_d   = S_IDLE;
          clk_cnt_d = CW'(0);
          done_d    = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_PRE:   bit_s = PREAMBLE[3'd7 - bit_cnt_d];
      S_HDR:   bit_s = hdr_s[3'd7 - bit_cnt_d];
      S_PAY:   bit_s = data_d[127];
      S_CRC:   bit_s = crc_q[3'd7 - bit_cnt_d];
      default: bit_s = 1'b1;
    endcase

    // The CRC absorbs each covered bit as that bit starts, so it is final when CRC begins.
    if (start_s) begin
      crc_d = 8'h00;
    end else if (adv_s && ((state_d == S_HDR) || (state_d == S_PAY))) begin
      crc_d = crc8_step(crc_q, bit_s);
    end else begin
      crc_d = crc_q;
    end

    serial_d = bit_s;
    busy_d   = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= CW'(0);
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 4'd0;
      data_q     <= 128'd0;
      len_q      <= 4'd0;
      dest_q     <= 2'd0;
      crc_q      <= 8'h00;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      len_q      <= len_d;
      dest_q     <= dest_d;
      crc_q      <= crc_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule
